pipe_mode_ctrl: RTL and testbench

Next-generation board-to-pipeline control block. It sequences camera configuration with a done handshake and debounces next/prev mode buttons. Mode cycles through NUM_MODES with wrap-around. Mode and NUM_FILT filter-enable changes are applied frame-aligned, with o_pipe_flush held until start of frame.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_mode_ctrl_if.sv | 30 +++
 rtl/btn_edge_db.sv | 52 +++++
 rtl/pipe_mode_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pipe_mode_ctrl.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline mode controller:
//   - cfg_state_t : camera configuration sequencer states
//   - MODE_PASSTHROUGH : mode index that forces all filters off
//   - LED_* : bit positions within o_status_leds
//   - CFG_MAX_RETRY : config restarts allowed before ERROR (timeout build only)
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        CFG_WAIT   = 3'd0,
        CFG_START  = 3'd1,
        CFG_BUSY   = 3'd2,
        CFG_ACTIVE = 3'd3,
        CFG_ERROR  = 3'd4
    } cfg_state_t;

    localparam int MODE_PASSTHROUGH = 0;

    localparam int LED_ACTIVE  = 0;
    localparam int LED_FLUSH   = 1;
    localparam int LED_ERROR   = 2;
    localparam int LED_RSVD    = 3;
    localparam int LED_MODE_LO = 4;

    localparam int CFG_MAX_RETRY = 3;

endpackage

// File: rtl/pipe_mode_ctrl_if.sv
// pipe_mode_ctrl_if
//   Frame/config handshake and applied pipeline settings.
//   i_sof        : start-of-frame pulse from the pipeline
//   i_cfg_done   : camera configuration complete
//   o_cfg_start  : one-cycle camera configuration start
//   o_mode       : applied pipeline mode (MW bits)
//   o_filt_en    : applied filter enables (NUM_FILT bits)
//   o_pipe_flush : pipeline flush, held until new settings are applied
//   Modports: slave = controller side, master = pipeline/camera side.
interface pipe_mode_ctrl_if #(
    parameter int MW       = 2,
    parameter int NUM_FILT = 3
);
    logic                i_sof;
    logic                i_cfg_done;
    logic                o_cfg_start;
    logic [MW-1:0]       o_mode;
    logic [NUM_FILT-1:0] o_filt_en;
    logic                o_pipe_flush;

    modport master (
        output i_sof, i_cfg_done,
        input  o_cfg_start, o_mode, o_filt_en, o_pipe_flush
    );

    modport slave (
        input  i_sof, i_cfg_done,
        output o_cfg_start, o_mode, o_filt_en, o_pipe_flush
    );
endinterface

// File: rtl/btn_edge_db.sv
// btn_edge_db
//   Raw button synchroniser, debouncer and rising-edge detector.
//   i_clk   : clock
//   i_rstn  : synchronous active-low reset
//   i_btn   : raw (asynchronous, bouncing) button
//   o_level : debounced level; changes after DB_COUNT consecutive
//             synchronised samples differ from the current level
//   o_rise  : one-cycle pulse, two cycles after o_level rises
module btn_edge_db #(
    parameter int DB_COUNT = 500_000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = $clog2(DB_COUNT + 1);

    logic          sync0;
    logic          sync1;
    logic [CW-1:0] cnt;
    logic          lvl_d1;
    logic          lvl_d2;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            cnt     <= '0;
            o_level <= 1'b0;
            lvl_d1  <= 1'b0;
            lvl_d2  <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            sync0 <= i_btn;
            sync1 <= sync0;
            // Any sample agreeing with the current level restarts the count.
            if (sync1 == o_level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_COUNT - 1)) begin
                o_level <= sync1;
                cnt     <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            lvl_d1 <= o_level;
            lvl_d2 <= lvl_d1;
            o_rise <= lvl_d1 & ~lvl_d2;
        end
    end
endmodule

// File: rtl/pipe_mode_ctrl.sv
// pipe_mode_ctrl
//   Camera configuration sequencer plus frame-aligned pipeline mode and
//   filter control driven by debounced next/prev buttons and filter switches.
//   i_clk         : clock
//   i_rstn        : synchronous active-low reset
//   i_btn_next    : raw button, advance mode
//   i_btn_prev    : raw button, previous mode
//   i_sw_filt     : raw filter switches (NUM_FILT)
//   o_status_leds : [0] config active, [1] flush, [2] config error,
//                   [3] reserved 0, [7:4] applied mode
//   bus           : pipe_mode_ctrl_if.slave (sof, cfg handshake, mode/filt/flush)
//   Build option PIPE_MODE_CTRL_CFG_TIMEOUT_EN: config timeout with up to
//   CFG_MAX_RETRY restarts, then a terminal ERROR state.
module pipe_mode_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_MODES   = 4,
    parameter int NUM_FILT    = 3,
    parameter int DB_COUNT    = 500_000,
    parameter int CFG_DELAY   = 1000,
    parameter int CFG_TIMEOUT = 2_500_000
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_btn_next,
    input  logic                i_btn_prev,
    input  logic [NUM_FILT-1:0] i_sw_filt,
    output logic [7:0]          o_status_leds,
    pipe_mode_ctrl_if.slave     bus
);
    localparam int MW = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1;
    localparam int DW = (CFG_DELAY > 0) ? $clog2(CFG_DELAY + 1) : 1;
    localparam logic [MW-1:0] MODE_LAST = MW'(NUM_MODES - 1);
    localparam logic [MW-1:0] MODE_PT   = MW'(MODE_PASSTHROUGH);

    cfg_state_t          state;
    logic [DW-1:0]       dly_cnt;
    logic                cfg_start;
    logic                active;
    logic                cfg_err;
    logic                next_level;
    logic                next_rise;
    logic                prev_level;
    logic                prev_rise;
    logic                unused_levels;
    logic [MW-1:0]       req;
    logic [NUM_FILT-1:0] sw_s0;
    logic [NUM_FILT-1:0] sw_s1;
    logic [NUM_FILT-1:0] tgt;
    logic                mismatch;
    logic [MW-1:0]       mode_q;
    logic [NUM_FILT-1:0] filt_q;
    logic                flush_q;

`ifdef PIPE_MODE_CTRL_CFG_TIMEOUT_EN
    localparam int TW = $clog2(CFG_TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic [1:0]    retry;
`else
    localparam int UNUSED_CFG_TIMEOUT = CFG_TIMEOUT;
`endif

    // Configuration sequencer; o_cfg_start is registered on entry to START.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state     <= CFG_WAIT;
            dly_cnt   <= '0;
            cfg_start <= 1'b0;
`ifdef PIPE_MODE_CTRL_CFG_TIMEOUT_EN
            to_cnt    <= '0;
            retry     <= '0;
`endif
        end else begin
            cfg_start <= 1'b0;
            case (state)
                CFG_WAIT: begin
`ifdef PIPE_MODE_CTRL_CFG_TIMEOUT_EN
                    retry <= '0;
`endif
                    if (dly_cnt == DW'(CFG_DELAY)) begin
                        state     <= CFG_START;
                        cfg_start <= 1'b1;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                CFG_START: begin
                    state <= CFG_BUSY;
`ifdef PIPE_MODE_CTRL_CFG_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                end
                CFG_BUSY: begin
                    if (bus.i_cfg_done) begin
                        state <= CFG_ACTIVE;
`ifdef PIPE_MODE_CTRL_CFG_TIMEOUT_EN
                    end else if (to_cnt == TW'(CFG_TIMEOUT - 1)) begin
                        to_cnt <= '0;
                        if (retry == 2'(CFG_MAX_RETRY)) begin
                            state <= CFG_ERROR;
                        end else begin
                            retry     <= retry + 1'b1;
                            state     <= CFG_START;
                            cfg_start <= 1'b1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                default: ; // ACTIVE and ERROR are terminal until reset
            endcase
        end
    end

    assign active = (state == CFG_ACTIVE);
`ifdef PIPE_MODE_CTRL_CFG_TIMEOUT_EN
    assign cfg_err = (state == CFG_ERROR);
`else
    assign cfg_err = 1'b0;
`endif

    btn_edge_db #(.DB_COUNT(DB_COUNT)) u_db_next (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_btn   (i_btn_next),
        .o_level (next_level),
        .o_rise  (next_rise)
    );

    btn_edge_db #(.DB_COUNT(DB_COUNT)) u_db_prev (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_btn   (i_btn_prev),
        .o_level (prev_level),
        .o_rise  (prev_rise)
    );

    // Only the rise pulses drive behaviour; levels are kept for observability.
    assign unused_levels = next_level ^ prev_level;

    // Passthrough forces filters off regardless of the switches.
    always_comb begin
        tgt      = (req == MODE_PT) ? '0 : sw_s1;
        mismatch = ({req, tgt} != {mode_q, filt_q});
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            req     <= '0;
            sw_s0   <= '0;
            sw_s1   <= '0;
            mode_q  <= '0;
            filt_q  <= '0;
            flush_q <= 1'b0;
        end else begin
            sw_s0 <= i_sw_filt;
            sw_s1 <= sw_s0;
            if (active) begin
                // Simultaneous next and prev cancel out.
                if (next_rise && !prev_rise) begin
                    req <= (req == MODE_LAST) ? '0 : req + 1'b1;
                end else if (prev_rise && !next_rise) begin
                    req <= (req == '0) ? MODE_LAST : req - 1'b1;
                end
                // Pending settings are applied only on a frame boundary.
                if (mismatch) begin
                    if (bus.i_sof) begin
                        mode_q  <= req;
                        filt_q  <= tgt;
                        flush_q <= 1'b0;
                    end else begin
                        flush_q <= 1'b1;
                    end
                end else begin
                    flush_q <= 1'b0;
                end
            end
        end
    end

    assign bus.o_cfg_start  = cfg_start;
    assign bus.o_mode       = mode_q;
    assign bus.o_filt_en    = filt_q;
    assign bus.o_pipe_flush = flush_q;

    always_comb begin
        o_status_leds                      = '0;
        o_status_leds[LED_ACTIVE]          = active;
        o_status_leds[LED_FLUSH]           = flush_q;
        o_status_leds[LED_ERROR]           = cfg_err;
        o_status_leds[LED_RSVD]            = 1'b0;
        o_status_leds[LED_MODE_LO +: 4]    = 4'(mode_q);
    end
endmodule

// File: tb/tb_pipe_mode_ctrl.sv
// tb_pipe_mode_ctrl
//   Directed, table-driven bench for pipe_mode_ctrl with NUM_MODES=4,
//   NUM_FILT=3, DB_COUNT=4, CFG_DELAY=8, CFG_TIMEOUT=16.
module tb_pipe_mode_ctrl;
    localparam int NM  = 4;
    localparam int NF  = 3;
    localparam int MWB = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          btn_next = 1'b0;
    logic          btn_prev = 1'b0;
    logic [NF-1:0] sw = '0;
    logic [7:0]    leds;

    int nvec = 0;
    int nerr = 0;
    int start_at;
    int act_at;
    int pulses;

    pipe_mode_ctrl_if #(.MW(MWB), .NUM_FILT(NF)) ifc ();

    pipe_mode_ctrl #(
        .NUM_MODES   (NM),
        .NUM_FILT    (NF),
        .DB_COUNT    (4),
        .CFG_DELAY   (8),
        .CFG_TIMEOUT (16)
    ) dut (
        .i_clk         (clk),
        .i_rstn        (rstn),
        .i_btn_next    (btn_next),
        .i_btn_prev    (btn_prev),
        .i_sw_filt     (sw),
        .o_status_leds (leds),
        .bus           (ifc.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          nxt;
        logic          prv;
        logic [NF-1:0] sw;
        logic          sof;
        logic          pre_flush;
        logic [MWB-1:0] mode;
        logic [NF-1:0] filt;
        logic          flush;
    } vec_t;

    vec_t vt[15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ifc.i_sof = 1'b0;
        ifc.i_cfg_done = 1'b0;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        sw = '0;
        repeat (3) tick();
        check("rst_cfg_start", 32'(ifc.o_cfg_start), 0);
        check("rst_outputs", {ifc.o_mode, ifc.o_filt_en, ifc.o_pipe_flush, leds}, 0);
        rstn = 1'b1;
    endtask

    task automatic press(input logic n, input logic p);
        btn_next = n;
        btn_prev = p;
        repeat (12) tick();
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (12) tick();
    endtask

    task automatic sof_pulse();
        ifc.i_sof = 1'b1;
        tick();
        ifc.i_sof = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.i_sof = 1'b0;
        ifc.i_cfg_done = 1'b0;

        //            nxt prv sw      sof pre mode  filt    flush
        vt[0]  = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 3'b000, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 2'd2, 3'b000, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 2'd3, 3'b000, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 2'd0, 3'b000, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 2'd1, 3'b000, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 3'b000, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 2'd2, 3'b000, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 3'b101, 1'b0, 1'b1, 2'd2, 3'b000, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 3'b101, 1'b1, 1'b1, 2'd2, 3'b101, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 3'b101, 1'b1, 1'b1, 2'd3, 3'b101, 1'b0};
        vt[10] = '{1'b1, 1'b0, 3'b101, 1'b1, 1'b1, 2'd0, 3'b000, 1'b0};
        vt[11] = '{1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0};
        vt[12] = '{1'b0, 1'b0, 3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0};
        vt[13] = '{1'b1, 1'b1, 3'b111, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0};
        vt[14] = '{1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 2'd3, 3'b000, 1'b0};

`ifdef PIPE_MODE_CTRL_CFG_TIMEOUT_EN
        // Config never completes: 4 start pulses, then terminal error.
        do_reset();
        pulses = 0;
        for (int n = 1; n <= 250; n++) begin
            tick();
            if (ifc.o_cfg_start) pulses++;
        end
        check("to_pulses", 32'(pulses), 4);
        check("to_err_led", 32'(leds[2]), 1);
        check("to_err_leds_all", 32'(leds), 32'h04);

        // Reset while BUSY restarts the WAIT delay.
        do_reset();
        start_at = 0;
        for (int n = 1; n <= 40 && start_at == 0; n++) begin
            tick();
            if (ifc.o_cfg_start) start_at = n;
        end
        repeat (3) tick();
        rstn = 1'b0;
        tick();
        check("busy_rst_leds", 32'(leds), 0);
        rstn = 1'b1;
        start_at = 0;
        for (int n = 1; n <= 40 && start_at == 0; n++) begin
            tick();
            if (ifc.o_cfg_start) start_at = n;
        end
        check("busy_rst_restart", 32'(start_at), 9);
`endif

        // Config sequence with an early (ignored) done and a real one later.
        do_reset();
        start_at = 0;
        act_at = 0;
        pulses = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ifc.o_cfg_start) begin
                pulses++;
                if (start_at == 0) start_at = n;
            end
            if (leds[0] && act_at == 0) act_at = n;
            ifc.i_cfg_done = (n == 3) || ((start_at != 0) && (n == start_at + 5));
        end
        ifc.i_cfg_done = 1'b0;
        check("cfg_start_cycle", 32'(start_at), 9);
        check("cfg_start_pulses", 32'(pulses), 1);
        check("cfg_active_cycle", 32'(act_at), 15);
        check("active_leds", 32'(leds), 32'h01);
        check("active_outputs", {ifc.o_mode, ifc.o_filt_en, ifc.o_pipe_flush}, 0);

        // Table-driven mode/filter vectors.
        for (int i = 0; i < 15; i++) begin
            sw = vt[i].sw;
            if (vt[i].nxt || vt[i].prv) press(vt[i].nxt, vt[i].prv);
            else repeat (4) tick();
            check($sformatf("v%0d_pre_flush", i), 32'(ifc.o_pipe_flush), 32'(vt[i].pre_flush));
            if (vt[i].sof) sof_pulse();
            check($sformatf("v%0d_mode", i), 32'(ifc.o_mode), 32'(vt[i].mode));
            check($sformatf("v%0d_filt", i), 32'(ifc.o_filt_en), 32'(vt[i].filt));
            check($sformatf("v%0d_flush", i), 32'(ifc.o_pipe_flush), 32'(vt[i].flush));
            check($sformatf("v%0d_led_mode", i), 32'(leds[7:4]), 32'(vt[i].mode));
        end

        // Two-cycle glitch on next must be rejected by the debouncer.
        btn_next = 1'b1;
        repeat (2) tick();
        btn_next = 1'b0;
        repeat (20) tick();
        check("glitch_flush", 32'(ifc.o_pipe_flush), 0);
        sof_pulse();
        check("glitch_mode", 32'(ifc.o_mode), 3);

        // Switch change reverted before sof: flush pulse only, outputs kept.
        sw = 3'b001;
        tick();
        tick();
        check("rev_flush_e2", 32'(ifc.o_pipe_flush), 0);
        tick();
        check("rev_flush_e3", 32'(ifc.o_pipe_flush), 1);
        sw = 3'b000;
        tick();
        tick();
        check("rev_flush_e5", 32'(ifc.o_pipe_flush), 1);
        tick();
        check("rev_flush_e6", 32'(ifc.o_pipe_flush), 0);
        sof_pulse();
        check("rev_mode", 32'(ifc.o_mode), 3);
        check("rev_filt", 32'(ifc.o_filt_en), 0);
        check("rev_leds", 32'(leds), 32'h31);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
